// File: rtl/inst_fetch_queue.sv
// Prefetching fetch unit: DEPTH-entry queue between instruction memory and ID; ack in cycle N shows at ID in N+1, no bypass.
// Fetch keeps running while ID stalls until the queue fills (refill allowed on a same-cycle pop); a redirect flushes in one cycle.
module inst_fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [ADDR_WIDTH-1:0]        redirect_addr,
  output logic                         inst_ren,
  output logic [ADDR_WIDTH-1:0]        inst_addr,
  input  logic [DATA_WIDTH-1:0]        inst_data,
  input  logic                         inst_ack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [ADDR_WIDTH-1:0]        out_addr_next,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(PC_STEP - 1);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [ADDR_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic push;
  logic pop;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(DEPTH));
    out_valid = ~empty & ~redirect & ~rst;
    pop       = out_valid & out_ready;
    inst_ren  = ~rst & ~redirect & (~full | pop);
    push      = inst_ren & inst_ack;

    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    // Redirect wins over any push/pop; push and pop are already masked by it.
    if (redirect) begin
      fetch_pc_d = redirect_addr & ALIGN_MASK;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      data_mem_q[wr_ptr_q] <= inst_data;
    end
  end

  assign inst_addr     = fetch_pc_q;
  assign out_addr      = pc_mem_q[rd_ptr_q];
  assign out_addr_next = pc_mem_q[rd_ptr_q] + STEP;
  assign out_data      = data_mem_q[rd_ptr_q];
  assign count         = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: DEPTH=4 and DEPTH=8 instances share stimulus and are
// checked against a queue-based model of the fetch/flush rules.
module tb_inst_fetch_queue;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic [DW-1:0] inst_data = '0;
  logic          inst_ack = 1'b0;
  logic          out_ready = 1'b0;

  logic          ren4, ren8, ov4, ov8, full4, full8, empty4, empty8;
  logic [AW-1:0] ia4, ia8, oa4, oa8, on4, on8;
  logic [DW-1:0] od4, od8;
  logic [2:0]    cnt4;
  logic [3:0]    cnt8;

  inst_fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4), .PC_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
    .inst_ren(ren4), .inst_addr(ia4), .inst_data(inst_data), .inst_ack(inst_ack),
    .out_valid(ov4), .out_ready(out_ready), .out_addr(oa4), .out_addr_next(on4),
    .out_data(od4), .count(cnt4), .full(full4), .empty(empty4));

  inst_fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(8), .PC_STEP(4)) dut8 (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
    .inst_ren(ren8), .inst_addr(ia8), .inst_data(inst_data), .inst_ack(inst_ack),
    .out_valid(ov8), .out_ready(out_ready), .out_addr(oa8), .out_addr_next(on8),
    .out_data(od8), .count(cnt8), .full(full8), .empty(empty8));

  logic          ren [2];
  logic          ov  [2];
  logic          fl  [2];
  logic          em  [2];
  logic [AW-1:0] ia  [2];
  logic [AW-1:0] oa  [2];
  logic [AW-1:0] on  [2];
  logic [DW-1:0] od  [2];
  int            cnt [2];

  assign ren[0] = ren4;  assign ren[1] = ren8;
  assign ov[0]  = ov4;   assign ov[1]  = ov8;
  assign fl[0]  = full4; assign fl[1]  = full8;
  assign em[0]  = empty4; assign em[1] = empty8;
  assign ia[0]  = ia4;   assign ia[1]  = ia8;
  assign oa[0]  = oa4;   assign oa[1]  = oa8;
  assign on[0]  = on4;   assign on[1]  = on8;
  assign od[0]  = od4;   assign od[1]  = od8;
  assign cnt[0] = int'(cnt4);
  assign cnt[1] = int'(cnt8);

  int total = 0;
  int bad = 0;

  // Reference model: each instance is a fetch PC plus a FIFO of (pc, instruction).
  int            dep [2] = '{4, 8};
  logic [AW-1:0] fpc [2];
  logic [AW-1:0] qp  [2][$];
  logic [DW-1:0] qd  [2][$];

  logic          e_valid [2];
  logic          e_pop   [2];
  logic          e_ren   [2];
  logic [AW-1:0] e_addr  [2];
  logic [DW-1:0] e_data  [2];
  int            e_cnt   [2];

  task automatic eval_exp();
    for (int k = 0; k < 2; k++) begin
      e_cnt[k]   = qp[k].size();
      e_valid[k] = !rst && !redirect && (e_cnt[k] > 0);
      e_pop[k]   = e_valid[k] && out_ready;
      e_ren[k]   = !rst && !redirect && ((e_cnt[k] < dep[k]) || e_pop[k]);
      e_addr[k]  = (e_cnt[k] > 0) ? qp[k][0] : '0;
      e_data[k]  = (e_cnt[k] > 0) ? qd[k][0] : '0;
    end
  endtask

  task automatic advance();
    eval_exp();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        fpc[k] = '0;
        qp[k].delete();
        qd[k].delete();
      end else if (redirect) begin
        fpc[k] = redirect_addr & ~32'h3;
        qp[k].delete();
        qd[k].delete();
      end else begin
        if (e_pop[k]) begin
          void'(qp[k].pop_front());
          void'(qd[k].pop_front());
        end
        if (e_ren[k] && inst_ack) begin
          qp[k].push_back(fpc[k]);
          qd[k].push_back(inst_data);
          fpc[k] = fpc[k] + 32'd4;
        end
      end
    end
    @(negedge clk);
    inst_data = $urandom();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; inst_ack = 1'b0; out_ready = 1'b0;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_ack = 1'b1; out_ready = 1'b1;
    advance();
    advance();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ren[k] !== 1'b0 || ov[k] !== 1'b0 || cnt[k] != 0 || em[k] !== 1'b1 ||
          fl[k] !== 1'b0 || ia[k] !== 32'h0) begin
        bad++;
        $display("FAIL reset k=%0d: ren=%b valid=%b count=%0d empty=%b full=%b addr=%h, want 0 0 0 1 0 00000000",
                 k, ren[k], ov[k], cnt[k], em[k], fl[k], ia[k]);
      end
    end
    rst = 1'b0; inst_ack = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    inst_ack = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      eval_exp();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (ov[k] !== (c > 0) || (c > 0 && (oa[k] !== 32'(4 * (c - 1)) ||
            on[k] !== 32'(4 * c) || od[k] !== e_data[k] || cnt[k] != 1))) begin
          bad++;
          $display("FAIL stream k=%0d cyc=%0d: valid=%b addr=%h next=%h data=%h count=%0d, want valid=%b addr=%h data=%h count=1",
                   k, c, ov[k], oa[k], on[k], od[k], cnt[k], c > 0, 32'(4 * (c - 1)), e_data[k]);
        end
      end
      advance();
    end
  endtask

  task automatic test_fill();
    do_reset();
    inst_ack = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (cnt[k] != ((i < dep[k]) ? i : dep[k]) || fl[k] !== (i >= dep[k]) ||
            ren[k] !== (i < dep[k])) begin
          bad++;
          $display("FAIL fill k=%0d i=%0d: count=%0d full=%b ren=%b, want count=%0d full=%b ren=%b",
                   k, i, cnt[k], fl[k], ren[k], (i < dep[k]) ? i : dep[k], i >= dep[k], i < dep[k]);
        end
      end
      advance();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (cnt[k] != ((dep[k] < 6) ? dep[k] : 6) || ren[k] !== 1'b1 || ov[k] !== 1'b1 ||
            oa[k] !== 32'(4 * c)) begin
          bad++;
          $display("FAIL fill_drain k=%0d c=%0d: count=%0d ren=%b valid=%b addr=%h, want count=%0d ren=1 valid=1 addr=%h",
                   k, c, cnt[k], ren[k], ov[k], oa[k], (dep[k] < 6) ? dep[k] : 6, 32'(4 * c));
        end
      end
      advance();
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    inst_ack = 1'b1; out_ready = 1'b0;
    advance();
    advance();
    inst_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (ia[k] !== 32'h8 || ren[k] !== 1'b1 || cnt[k] != 2) begin
          bad++;
          $display("FAIL wait k=%0d c=%0d: addr=%h ren=%b count=%0d, want addr=00000008 ren=1 count=2",
                   k, c, ia[k], ren[k], cnt[k]);
        end
      end
      advance();
    end
    inst_ack = 1'b1;
    advance();
    inst_ack = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ia[k] !== 32'hC || cnt[k] != 3) begin
        bad++;
        $display("FAIL wait_ack k=%0d: addr=%h count=%0d, want addr=0000000c count=3", k, ia[k], cnt[k]);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (ov[k] !== 1'b1 || oa[k] !== 32'(4 * c)) begin
          bad++;
          $display("FAIL wait_order k=%0d c=%0d: valid=%b addr=%h, want valid=1 addr=%h",
                   k, c, ov[k], oa[k], 32'(4 * c));
        end
      end
      advance();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect();
    logic [AW-1:0] tgt;
    do_reset();
    redirect = 1'b1; redirect_addr = 32'h10;
    advance();
    redirect = 1'b0; inst_ack = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) advance();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (cnt[k] != 4 || oa[k] !== 32'h10) begin
        bad++;
        $display("FAIL redir_fill k=%0d: count=%0d head=%h, want count=4 head=00000010", k, cnt[k], oa[k]);
      end
    end
    redirect = 1'b1; redirect_addr = 32'h43; out_ready = 1'b1; inst_ack = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ov[k] !== 1'b0 || ren[k] !== 1'b0) begin
        bad++;
        $display("FAIL redir_cycle k=%0d: valid=%b ren=%b, want 0 0", k, ov[k], ren[k]);
      end
    end
    advance();
    redirect = 1'b0; inst_ack = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (cnt[k] != 0 || ov[k] !== 1'b0 || ia[k] !== 32'h40 || ren[k] !== 1'b1) begin
        bad++;
        $display("FAIL redir_after k=%0d: count=%0d valid=%b addr=%h ren=%b, want 0 0 00000040 1",
                 k, cnt[k], ov[k], ia[k], ren[k]);
      end
    end
    inst_ack = 1'b1;
    advance();
    inst_ack = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ov[k] !== 1'b1 || oa[k] !== 32'h40 || on[k] !== 32'h44) begin
        bad++;
        $display("FAIL redir_refetch k=%0d: valid=%b addr=%h next=%h, want 1 00000040 00000044",
                 k, ov[k], oa[k], on[k]);
      end
    end
    redirect = 1'b1; inst_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tgt = $urandom();
      redirect_addr = tgt;
      advance();
      #1;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (ia[k] !== (tgt & ~32'h3) || cnt[k] != 0 || ov[k] !== 1'b0 || ren[k] !== 1'b0) begin
          bad++;
          $display("FAIL redir_held k=%0d c=%0d: addr=%h count=%0d valid=%b ren=%b, want addr=%h count=0 valid=0 ren=0",
                   k, c, ia[k], cnt[k], ov[k], ren[k], tgt & ~32'h3);
        end
      end
    end
    redirect = 1'b0; inst_ack = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    inst_ack = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) advance();
    rst = 1'b1; out_ready = 1'b1;
    advance();
    rst = 1'b0; inst_ack = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (cnt[k] != 0 || ia[k] !== 32'h0 || ov[k] !== 1'b0 || em[k] !== 1'b1) begin
        bad++;
        $display("FAIL mid_reset k=%0d: count=%0d addr=%h valid=%b empty=%b, want 0 00000000 0 1",
                 k, cnt[k], ia[k], ov[k], em[k]);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      inst_ack  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      redirect  = ($urandom_range(0, 99) < 3);
      redirect_addr = $urandom();
      rst       = ($urandom_range(0, 199) == 0);
      #1;
      eval_exp();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (ren[k] !== e_ren[k] || ia[k] !== fpc[k] || ov[k] !== e_valid[k] || cnt[k] != e_cnt[k] ||
            fl[k] !== (e_cnt[k] == dep[k]) || em[k] !== (e_cnt[k] == 0) ||
            (e_valid[k] && (oa[k] !== e_addr[k] || on[k] !== e_addr[k] + 32'd4 || od[k] !== e_data[k]))) begin
          bad++;
          $display("FAIL random k=%0d cyc=%0d: ren=%b ia=%h valid=%b addr=%h data=%h count=%0d full=%b empty=%b, want ren=%b ia=%h valid=%b addr=%h data=%h count=%0d",
                   k, c, ren[k], ia[k], ov[k], oa[k], od[k], cnt[k], fl[k], em[k],
                   e_ren[k], fpc[k], e_valid[k], e_addr[k], e_data[k], e_cnt[k]);
        end
      end
      advance();
    end
    rst = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_fill();
    test_wait_states();
    test_redirect();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
